// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch FSM with next-PC prediction and a decoder FIFO; optional BHT under `IFETCH_BHT_EN
module inst_fetcher #(
  parameter int QUEUE_DEPTH = 8,
  parameter int BHT_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] rob_new_pc,
  output logic [31:0] pc,
  output logic        start_fetch,
  input  logic        fetch_ready,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_pred_taken,
  output logic [31:0] dec_pred_pc,
  input  logic        dec_ready,
  input  logic        bht_upd_valid,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] FULL = QUEUE_DEPTH[AW:0];
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred_pc;
  } entry_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  entry_t        fifo_q [QUEUE_DEPTH];
  entry_t        fifo_d [QUEUE_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          accept, pop, is_jal, is_br, bht_taken, pred_taken;
  logic [31:0]   imm_j, imm_b, pred_pc;
  entry_t        head;
  assign pc = pc_q;
  assign start_fetch = state_q == WAIT;
  assign dec_valid = cnt_q != '0;
  assign pop = dec_valid && dec_ready;
  assign accept = state_q == WAIT && fetch_ready && inst_addr == pc_q && !rob_clear_up;
  assign head = fifo_q[rd_q];
  assign dec_inst = dec_valid ? head.inst : '0;
  assign dec_pc = dec_valid ? head.pc : '0;
  assign dec_pred_taken = dec_valid && head.taken;
  assign dec_pred_pc = dec_valid ? head.pred_pc : '0;
  assign is_jal = inst[6:0] == 7'b1101111;
  assign is_br = inst[6:0] == 7'b1100011;
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign pred_taken = is_jal || (is_br && bht_taken);
  assign pred_pc = is_jal ? pc_q + imm_j : (is_br && bht_taken) ? pc_q + imm_b : pc_q + 32'd4;
`ifdef IFETCH_BHT_EN
  logic [1:0] bht_q [2**BHT_BITS];
  logic [1:0] bht_d [2**BHT_BITS];
  logic [1:0] upd_cnt;
  logic       unused_upd;
  assign unused_upd = ^{bht_upd_pc[31:BHT_BITS+2], bht_upd_pc[1:0]};
  assign upd_cnt = bht_q[bht_upd_pc[BHT_BITS+1:2]];
  assign bht_taken = bht_q[pc_q[BHT_BITS+1:2]][1];
  always_comb begin
    bht_d = bht_q;
    if (bht_upd_valid)
      bht_d[bht_upd_pc[BHT_BITS+1:2]] = bht_upd_taken ? (upd_cnt == 2'b11 ? upd_cnt : upd_cnt + 2'b01)
                                                      : (upd_cnt == 2'b00 ? upd_cnt : upd_cnt - 2'b01);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in)
      for (int i = 0; i < 2**BHT_BITS; i++) bht_q[i] <= 2'b01;
    else if (rdy_in)
      bht_q <= bht_d;
  end
`else
  logic unused_bht;
  assign unused_bht = ^{bht_upd_valid, bht_upd_taken, bht_upd_pc, BHT_BITS[0]};
  assign bht_taken = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    fifo_d = fifo_q;
    if (rob_clear_up) begin
      state_d = IDLE;
      pc_d = rob_new_pc;
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      // a same-cycle pop frees the slot, so a full queue re-issues immediately
      if (state_q == IDLE && (cnt_q != FULL || pop)) state_d = WAIT;
      if (accept) begin
        fifo_d[wr_q] = '{inst: inst, pc: pc_q, taken: pred_taken, pred_pc: pred_pc};
        wr_d = wr_q + AW'(1);
        pc_d = pred_pc;
        state_d = IDLE;
      end
      rd_d = rd_q + AW'(pop);
      cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q <= pc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      fifo_q <= fifo_d;
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed checks of fetch sequencing, prediction, FIFO backpressure, stale responses and flush
module tb_inst_fetcher;
  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] JAL  = 32'h1000006F;
  localparam logic [31:0] BEQ  = 32'hFE000CE3;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear_up, fetch_ready, dec_ready, bht_upd_valid, bht_upd_taken;
  logic [31:0] rob_new_pc, inst, inst_addr, bht_upd_pc;
  logic start_fetch, dec_valid, dec_pred_taken;
  logic [31:0] pc, dec_inst, dec_pc, dec_pred_pc;
  int tests = 0;
  int fails = 0;
  int pushes = 0;
  bit mem_en = 1'b0;
  always #5 clk_in = ~clk_in;
  inst_fetcher dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .rob_new_pc(rob_new_pc), .pc(pc), .start_fetch(start_fetch), .fetch_ready(fetch_ready),
    .inst(inst), .inst_addr(inst_addr), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken), .dec_pred_pc(dec_pred_pc),
    .dec_ready(dec_ready), .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc),
    .bht_upd_taken(bht_upd_taken)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return a == 32'h8 ? JAL : a == 32'h10 ? BEQ : ADDI;
  endfunction
  task automatic tick_raw(input logic fr, input logic [31:0] ia, input logic [31:0] in);
    fetch_ready = fr;
    inst_addr = ia;
    inst = in;
    if (fr && ia == pc && start_fetch && !rob_clear_up && rdy_in && !rst_in) pushes++;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask
  task automatic tick();
    tick_raw(mem_en && start_fetch, pc, mem_at(pc));
  endtask
  task automatic wait_pushes(input int n);
    for (int i = 0; i < 60 && pushes < n; i++) tick();
    check("push_timeout", pushes, n);
  endtask
  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; rob_new_pc = '0;
    fetch_ready = 1'b0; inst = '0; inst_addr = '0; dec_ready = 1'b0;
    bht_upd_valid = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;
    @(negedge clk_in);
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_sf", start_fetch, 32'h0);
    check("rst_valid", dec_valid, 32'h0);
    check("rst_inst", dec_inst, 32'h0);
    check("rst_pred_pc", dec_pred_pc, 32'h0);
    rst_in = 1'b0;
    mem_en = 1'b1;
    wait_pushes(3);
    mem_en = 1'b0;
    check("jal_next_pc", pc, 32'h108);
    check("sf_drop", start_fetch, 32'h0);
    check("head0_pc", dec_pc, 32'h0);
    check("head0_inst", dec_inst, ADDI);
    check("head0_taken", dec_pred_taken, 32'h0);
    check("head0_pred", dec_pred_pc, 32'h4);
    dec_ready = 1'b1;
    tick();
    check("head1_pc", dec_pc, 32'h4);
    check("head1_pred", dec_pred_pc, 32'h8);
    tick();
    check("head2_pc", dec_pc, 32'h8);
    check("head2_inst", dec_inst, JAL);
    check("jal_pred_pc", dec_pred_pc, 32'h108);
    tick();
    dec_ready = 1'b0;
    check("drain_valid", dec_valid, 32'h0);
    check("drain_pc", dec_pc, 32'h0);
    check("wait_sf", start_fetch, 32'h1);
    check("wait_pc", pc, 32'h108);
    tick_raw(1'b1, 32'h44, ADDI);
    check("stale_sf", start_fetch, 32'h1);
    check("stale_pc", pc, 32'h108);
    check("stale_valid", dec_valid, 32'h0);
    rdy_in = 1'b0;
    mem_en = 1'b1;
    tick();
    tick();
    check("hold_valid", dec_valid, 32'h0);
    check("hold_pc", pc, 32'h108);
    check("hold_sf", start_fetch, 32'h1);
    rdy_in = 1'b1;
    wait_pushes(11);
    repeat (4) tick();
    check("full_sf", start_fetch, 32'h0);
    check("full_pc", pc, 32'h128);
    check("full_head", dec_pc, 32'h108);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("refill_sf", start_fetch, 32'h1);
    check("refill_head", dec_pc, 32'h10C);
    rob_clear_up = 1'b1;
    rob_new_pc = 32'h200;
    tick();
    rob_clear_up = 1'b0;
    check("flush_valid", dec_valid, 32'h0);
    check("flush_sf", start_fetch, 32'h0);
    check("flush_pc", pc, 32'h200);
    wait_pushes(pushes + 1);
    check("post_flush_head", dec_pc, 32'h200);
    check("post_flush_valid", dec_valid, 32'h1);
    rob_clear_up = 1'b1;
    rob_new_pc = 32'h10;
    bht_upd_valid = 1'b1;
    bht_upd_pc = 32'h10;
    bht_upd_taken = 1'b1;
    tick();
    tick();
    rob_clear_up = 1'b0;
    bht_upd_valid = 1'b0;
    wait_pushes(pushes + 1);
    check("br_head", dec_pc, 32'h10);
`ifdef IFETCH_BHT_EN
    check("br_next_pc", pc, 32'h8);
    check("br_taken", dec_pred_taken, 32'h1);
    check("br_pred_pc", dec_pred_pc, 32'h8);
`else
    check("br_next_pc", pc, 32'h14);
    check("br_taken", dec_pred_taken, 32'h0);
    check("br_pred_pc", dec_pred_pc, 32'h14);
`endif
    mem_en = 1'b0;
    tick();
    check("pre_rst_sf", start_fetch, 32'h1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_sf", start_fetch, 32'h0);
    check("mid_rst_valid", dec_valid, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
